// File: rtl/seq_mult_ctrl_pkg.sv
// Shared types and constants for the sequential shift-and-add multiplier.
package seq_mult_ctrl_pkg;

   localparam int N_DEF = 4;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_ADD   = 3'd2,
      S_SHIFT = 3'd3,
      S_DONE  = 3'd4
   } state_t;

endpackage

// File: rtl/seq_mult_ctrl_if.sv
// Start/busy/done handshake plus operands and product for the multiplier.
interface seq_mult_ctrl_if #(
   parameter int N = 4
) ();

   logic             start;
   logic [N-1:0]     a;
   logic [N-1:0]     b;
   logic             busy;
   logic             done;
   logic [2*N-1:0]   product;

   modport master (output start, a, b, input busy, done, product);
   modport slave  (input start, a, b, output busy, done, product);

endinterface

// File: rtl/seq_mult_ctrl_adder_n.sv
// Combinational N-bit ripple-carry adder, shared across all multiply iterations.
module adder_n #(
   parameter int N = 4
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         cin,
   output logic [N-1:0] s,
   output logic         cout
);

   logic [N:0] c;

   assign c[0] = cin;

   for (genvar gi = 0; gi < N; gi++) begin : g_bit
      assign s[gi]   = a[gi] ^ b[gi] ^ c[gi];
      assign c[gi+1] = (a[gi] & b[gi]) | (c[gi] & (a[gi] ^ b[gi]));
   end

   assign cout = c[N];

endmodule

// File: rtl/seq_mult_ctrl.sv
// Shift-and-add multiplier controller: one adder reused over N add/shift rounds.
//
//   state   | meaning
//   --------+-----------------------------------------------------
//   IDLE    | waiting for start; operands latched on acceptance
//   LOAD    | clear accumulator half of P and iteration counter
//   ADD     | add M into accumulator when multiplier LSB is set
//   SHIFT   | shift P right one bit, advance counter
//   DONE    | product valid, one-cycle done pulse
module seq_mult_ctrl
   import seq_mult_ctrl_pkg::*;
#(
   parameter int N = N_DEF
) (
   input  logic          clk,
   input  logic          rst_n,
   seq_mult_ctrl_if.slave bus
);

   localparam int CW = $clog2(N) + 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

   state_t           state, state_nx;
   logic [N-1:0]     m_q, m_nx;
   logic [2*N:0]     p_q, p_nx;
   logic [CW-1:0]    cnt_q, cnt_nx;
   logic [2*N-1:0]   product_q, product_nx;
   logic             busy_q, busy_nx;
   logic             done_q, done_nx;
   logic [N-1:0]     sum;
   logic             carry;

   adder_n #(.N(N)) u_adder (
      .a    (p_q[2*N-1:N]),
      .b    (m_q),
      .cin  (1'b0),
      .s    (sum),
      .cout (carry)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         m_q       <= '0;
         p_q       <= '0;
         cnt_q     <= '0;
         product_q <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state     <= state_nx;
         m_q       <= m_nx;
         p_q       <= p_nx;
         cnt_q     <= cnt_nx;
         product_q <= product_nx;
         busy_q    <= busy_nx;
         done_q    <= done_nx;
      end
   end

   always_comb begin
      state_nx   = state;
      m_nx       = m_q;
      p_nx       = p_q;
      cnt_nx     = cnt_q;
      product_nx = product_q;
      unique case (state)
         S_IDLE: begin
            if (bus.start) begin
               m_nx        = bus.a;
               p_nx[N-1:0] = bus.b;
               state_nx    = S_LOAD;
            end
         end
         S_LOAD: begin
            p_nx[2*N:N] = '0;
            cnt_nx      = '0;
            state_nx    = S_ADD;
         end
         S_ADD: begin
            if (p_q[0]) begin
               p_nx[2*N:N] = {carry, sum};
            end
            state_nx = S_SHIFT;
         end
         S_SHIFT: begin
            p_nx   = p_q >> 1;
            cnt_nx = cnt_q + CW'(1);
            if (cnt_q == CNT_LAST) begin
               // Capture on entry to DONE so product is valid alongside the done pulse.
               product_nx = p_nx[2*N-1:0];
               state_nx   = S_DONE;
            end else begin
               state_nx = S_ADD;
            end
         end
         S_DONE: begin
            state_nx = S_IDLE;
         end
         default: begin
            state_nx = S_IDLE;
         end
      endcase
   end

   // Outputs are registered from the next state so they line up with the state they describe.
   always_comb begin
      busy_nx = (state_nx == S_LOAD) || (state_nx == S_ADD) || (state_nx == S_SHIFT);
      done_nx = (state_nx == S_DONE);
   end

   assign bus.busy    = busy_q;
   assign bus.done    = done_q;
   assign bus.product = product_q;

endmodule

// File: tb/tb_seq_mult_ctrl.sv
// Directed bench for seq_mult_ctrl with N=4: latency, handshake, reset abort, full product table.
module tb_seq_mult_ctrl;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   seq_mult_ctrl_if #(.N(4)) bus ();

   seq_mult_ctrl #(.N(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Pulse start for one edge, then watch 20 sampled cycles; sample n=1 follows the accept edge.
   task automatic run_mult(input logic [3:0] av, input logic [3:0] bv,
                           output logic [7:0] prod, output int lat,
                           output int done_w, output int busy_c);
      prod   = '0;
      lat    = 0;
      done_w = 0;
      busy_c = 0;
      bus.a     = av;
      bus.b     = bv;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      for (int n = 1; n <= 20; n++) begin
         if (bus.busy) busy_c++;
         if (bus.done) begin
            if (lat == 0) lat = n;
            done_w++;
            prod = bus.product;
         end
         tick();
      end
   endtask

   logic [7:0] prod;
   int         lat, done_w, busy_c;
   int         dcount, last_done, viol;

   logic [3:0] va [3] = '{4'd9, 4'd0, 4'd7};
   logic [3:0] vb [3] = '{4'd13, 4'd11, 4'd1};
   logic [7:0] vp [3] = '{8'd117, 8'd0, 8'd7};

   initial begin
      checks    = 0;
      errors    = 0;
      rst_n     = 1'b0;
      bus.start = 1'b0;
      bus.a     = '0;
      bus.b     = '0;
      tick();
      tick();
      chk("rst_busy", 32'(bus.busy), 0);
      chk("rst_done", 32'(bus.done), 0);
      chk("rst_product", 32'(bus.product), 0);
      rst_n = 1'b1;
      tick();

      run_mult(4'd15, 4'd15, prod, lat, done_w, busy_c);
      chk("max_latency", 32'(lat), 10);
      chk("max_product", 32'(prod), 32'h E1);
      chk("max_busy_cycles", 32'(busy_c), 9);
      chk("max_done_width", 32'(done_w), 1);

      for (int i = 0; i < 3; i++) begin
         run_mult(va[i], vb[i], prod, lat, done_w, busy_c);
         chk($sformatf("vec%0d_product", i), 32'(prod), 32'(vp[i]));
         chk($sformatf("vec%0d_done_width", i), 32'(done_w), 1);
         chk($sformatf("vec%0d_latency", i), 32'(lat), 10);
      end

      // Operand and start changes while busy or in DONE must be ignored.
      bus.a     = 4'd3;
      bus.b     = 4'd5;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      dcount = 0;
      prod   = '0;
      for (int n = 1; n <= 25; n++) begin
         if (bus.done) begin
            dcount++;
            prod = bus.product;
         end
         if (n == 3 || n == 9 || n == 10) begin
            bus.a     = 4'd15;
            bus.b     = 4'd15;
            bus.start = 1'b1;
         end else begin
            bus.start = 1'b0;
         end
         tick();
      end
      chk("ignore_product", 32'(prod), 15);
      chk("ignore_done_count", 32'(dcount), 1);
      chk("ignore_product_hold", 32'(bus.product), 15);

      // Reset mid-operation.
      bus.a     = 4'd6;
      bus.b     = 4'd6;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      for (int n = 2; n <= 5; n++) tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      chk("abort_busy", 32'(bus.busy), 0);
      chk("abort_done", 32'(bus.done), 0);
      chk("abort_product", 32'(bus.product), 0);
      chk("abort_state", 32'(dut.state), 0);
      run_mult(4'd2, 4'd3, prod, lat, done_w, busy_c);
      chk("after_abort_product", 32'(prod), 6);

      // start held high: back-to-back operations.
      bus.a     = 4'd2;
      bus.b     = 4'd8;
      bus.start = 1'b1;
      dcount    = 0;
      last_done = 0;
      viol      = 0;
      for (int n = 1; n <= 60; n++) begin
         tick();
         if (bus.done) begin
            dcount++;
            if (last_done != 0) chk("held_period", 32'(n - last_done), 11);
            chk("held_product", 32'(bus.product), 16);
            last_done = n;
         end else if (last_done != 0 && bus.product !== 8'd16) begin
            viol++;
         end
      end
      bus.start = 1'b0;
      chk("held_done_count", 32'(dcount), 5);
      chk("held_product_stable", 32'(viol), 0);
      for (int n = 0; n < 15; n++) tick();

      // Full operand table.
      dcount = 0;
      for (int ia = 0; ia < 16; ia++) begin
         for (int ib = 0; ib < 16; ib++) begin
            run_mult(4'(ia), 4'(ib), prod, lat, done_w, busy_c);
            dcount += done_w;
            chk($sformatf("table_%0dx%0d", ia, ib), 32'(prod), 32'(ia * ib));
         end
      end
      chk("table_done_count", 32'(dcount), 256);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
